// File: rtl/branch_resolver_if.sv
// Decoder/ALU/PC-facing signal bundle for branch_resolver.
// BRANCH_STATS_EN adds the taken/not-taken statistics counters.
interface branch_resolver_if;
  logic        start;
  logic [9:0]  pc;
  logic        br_valid;
  logic [1:0]  br_kind;
  logic [4:0]  br_imm;
  logic        flag_we;
  logic        alu_z;
  logic        alu_n;
  logic        lut_we;
  logic [3:0]  lut_addr;
  logic [3:0]  lut_data;
  logic        branch;
  logic        taken;
  logic [7:0]  target;
  logic        LOOKUP2;
  logic        busy;
  logic        done;
  logic        timeout;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;
`endif

  modport slave (
    input  start, pc, br_valid, br_kind, br_imm, flag_we, alu_z, alu_n,
           lut_we, lut_addr, lut_data,
    output branch, taken, target, LOOKUP2, busy, done, timeout
`ifdef BRANCH_STATS_EN
    , output taken_cnt, not_taken_cnt
`endif
  );

  modport master (
    output start, pc, br_valid, br_kind, br_imm, flag_we, alu_z, alu_n,
           lut_we, lut_addr, lut_data,
    input  branch, taken, target, LOOKUP2, busy, done, timeout
`ifdef BRANCH_STATS_EN
    , input taken_cnt, not_taken_cnt
`endif
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolution: condition flags, branch evaluation, absolute-target LUT and run control.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_resolver #(
  parameter logic [9:0]  HALT_PC    = 10'd63,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             RST_N,
  branch_resolver_if.slave bus
);
  localparam int unsigned CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic            r_z;
  logic            r_n;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_lut [16];

  logic            w_run;
  logic            w_branch;
  logic            w_cond;
  logic            w_lookup2;
  logic [7:0]      w_target;
  logic            w_cnt_last;
  logic            w_cnt_sat;

  assign w_run      = (r_state == S_RUN);
  assign w_branch   = bus.br_valid & w_run;
  assign w_cnt_last = (r_cnt == CW'(MAX_CYCLES - 1));
  assign w_cnt_sat  = &r_cnt;

  // Condition uses registered flags, so a same-cycle flag load does not affect it
  always_comb begin
    w_cond = 1'b0;
    case (bus.br_kind)
      2'b00:   w_cond = r_z;
      2'b01:   w_cond = ~r_z;
      2'b10:   w_cond = r_n;
      default: w_cond = 1'b1;
    endcase
  end

  always_comb begin
    w_target  = 8'h00;
    w_lookup2 = 1'b0;
    if (w_branch) begin
      if (bus.br_kind == 2'b11) begin
        w_target  = {4'b0000, r_lut[bus.br_imm[3:0]]};
        w_lookup2 = 1'b1;
      end else begin
        w_target  = {{3{bus.br_imm[4]}}, bus.br_imm};
      end
    end
  end

  assign bus.branch  = w_branch;
  assign bus.taken   = w_branch & w_cond;
  assign bus.target  = w_target;
  assign bus.LOOKUP2 = w_lookup2;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.timeout = r_timeout;

  // Run control; start outranks halt address and budget expiry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (bus.start) begin
      r_state   <= S_RUN;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.pc == HALT_PC) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_cnt_last) begin
            r_state   <= S_HALT;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_cnt <= '0;
    end else if (bus.start) begin
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_cnt <= '0;
    end else if (w_run) begin
      if (bus.flag_we) begin
        r_z <= bus.alu_z;
        r_n <= bus.alu_n;
      end
      if (!w_cnt_sat) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Reads see the old entry during a write; reset restores the identity pattern
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) r_lut[i] <= 4'(i);
    end else if (bus.lut_we) begin
      r_lut[bus.lut_addr] <= bus.lut_data;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_not_taken_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_taken_cnt     <= 16'h0000;
      r_not_taken_cnt <= 16'h0000;
    end else if (bus.start) begin
      r_taken_cnt     <= 16'h0000;
      r_not_taken_cnt <= 16'h0000;
    end else if (w_branch) begin
      if (w_cond) begin
        if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
      end else begin
        if (r_not_taken_cnt != 16'hFFFF) r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
      end
    end
  end

  assign bus.taken_cnt     = r_taken_cnt;
  assign bus.not_taken_cnt = r_not_taken_cnt;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed test-plan sequences, then random traffic,
// checked against a run-cycle-counting behavioural model.
module tb_branch_resolver;
  localparam int MAXC = 8;
  localparam int HALT = 63;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  branch_resolver_if bif();

  branch_resolver #(.HALT_PC(10'd63), .MAX_CYCLES(MAXC)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bif)
  );

  typedef struct {
    logic       br;
    logic       tk;
    logic [7:0] tg;
    logic       lk;
    logic       bsy;
    logic       dn;
    logic       to;
    int         tc;
    int         ntc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // stimulus for the current cycle
  logic       s_rst, s_start, s_bv, s_fwe, s_z, s_n, s_lwe;
  logic [9:0] s_pc;
  logic [1:0] s_kind;
  logic [4:0] s_imm;
  logic [3:0] s_la, s_ld;

  // behavioural model: mode 0=idle 1=run 2=halt, m_rc = RUN cycles elapsed since start
  int m_mode, m_rc, m_tc, m_ntc;
  bit m_z, m_n, m_to;
  int m_lut [16];

  task automatic model_reset();
    m_mode = 0; m_rc = 0; m_tc = 0; m_ntc = 0;
    m_z = 1'b0; m_n = 1'b0; m_to = 1'b0;
    for (int i = 0; i < 16; i++) m_lut[i] = i;
  endtask

  task automatic model_edge(input logic br, input logic tk);
    if (!s_rst) begin
      model_reset();
      return;
    end
    if (s_start) begin
      m_mode = 1; m_rc = 0; m_to = 1'b0; m_z = 1'b0; m_n = 1'b0; m_tc = 0; m_ntc = 0;
    end else if (m_mode == 1) begin
      if (br) begin
        if (tk) m_tc  = (m_tc  < 65535) ? m_tc + 1  : m_tc;
        else    m_ntc = (m_ntc < 65535) ? m_ntc + 1 : m_ntc;
      end
      if (s_fwe) begin m_z = s_z; m_n = s_n; end
      if (int'(s_pc) == HALT) m_mode = 2;
      else begin
        m_rc = m_rc + 1;
        if (m_rc == MAXC) begin m_mode = 2; m_to = 1'b1; end
      end
    end
    if (s_lwe) m_lut[s_la] = int'(s_ld);
  endtask

  task automatic drive();
    RST_N        = s_rst;
    bif.start    = s_start;
    bif.pc       = s_pc;
    bif.br_valid = s_bv;
    bif.br_kind  = s_kind;
    bif.br_imm   = s_imm;
    bif.flag_we  = s_fwe;
    bif.alu_z    = s_z;
    bif.alu_n    = s_n;
    bif.lut_we   = s_lwe;
    bif.lut_addr = s_la;
    bif.lut_data = s_ld;
  endtask

  task automatic issue();
    exp_t e;
    bit   c;
    int   v;
    drive();
    if (!s_rst) model_reset();
    case (s_kind)
      2'd0:    c = m_z;
      2'd1:    c = !m_z;
      2'd2:    c = m_n;
      default: c = 1'b1;
    endcase
    e.br = s_rst && (m_mode == 1) && s_bv;
    e.tk = e.br && c;
    e.tg = 8'h00;
    e.lk = 1'b0;
    if (e.br) begin
      if (s_kind == 2'd3) begin
        e.tg = 8'(m_lut[int'(s_imm) % 16]);
        e.lk = 1'b1;
      end else begin
        v = (int'(s_imm) >= 16) ? int'(s_imm) - 32 : int'(s_imm);
        e.tg = 8'(v & 255);
      end
    end
    e.bsy = (m_mode == 1);
    e.dn  = (m_mode == 2);
    e.to  = m_to;
    e.tc  = m_tc;
    e.ntc = m_ntc;
    q.push_back(e);
    @(posedge CLK);
    #1;
    model_edge(e.br, e.tk);
  endtask

  task automatic cyc(input logic st, input logic [9:0] pc, input logic bv, input logic [1:0] k,
                     input logic [4:0] imm, input logic fwe, input logic z,
                     input logic lwe, input logic [3:0] la, input logic [3:0] ld);
    s_rst = 1'b1; s_start = st; s_pc = pc; s_bv = bv; s_kind = k; s_imm = imm;
    s_fwe = fwe; s_z = z; s_n = 1'b0; s_lwe = lwe; s_la = la; s_ld = ld;
    issue();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  exp_t m_e;
  logic m_ok;
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        m_ok = (bif.branch === m_e.br) && (bif.taken === m_e.tk) && (bif.target === m_e.tg) &&
               (bif.LOOKUP2 === m_e.lk) && (bif.busy === m_e.bsy) && (bif.done === m_e.dn) &&
               (bif.timeout === m_e.to);
`ifdef BRANCH_STATS_EN
        m_ok = m_ok && (bif.taken_cnt === 16'(m_e.tc)) && (bif.not_taken_cnt === 16'(m_e.ntc));
`endif
        n_cmp++;
        if (!m_ok) begin
          n_bad++;
          $display("FAIL outputs @%0t: got br=%b tk=%b tg=%h lk=%b busy=%b done=%b to=%b, want br=%b tk=%b tg=%h lk=%b busy=%b done=%b to=%b (cnt want %0d/%0d)",
                   $time, bif.branch, bif.taken, bif.target, bif.LOOKUP2, bif.busy, bif.done,
                   bif.timeout, m_e.br, m_e.tk, m_e.tg, m_e.lk, m_e.bsy, m_e.dn, m_e.to,
                   m_e.tc, m_e.ntc);
        end
      end
    end
  end

  initial begin
    s_rst = 1'b0; s_start = 1'b0; s_pc = 10'd0; s_bv = 1'b0; s_kind = 2'd0; s_imm = 5'd0;
    s_fwe = 1'b0; s_z = 1'b0; s_n = 1'b0; s_lwe = 1'b0; s_la = 4'd0; s_ld = 4'd0;
    model_reset();
    drive();
    @(posedge CLK);
    #1;
    issue();
    issue();

    // LUT jump, same-cycle write returns old value, then new value
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd5,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd5,    1'b0, 1'b0, 1'b1, 4'd5, 4'hA);
    cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd5,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // Z flag relative branches
    cyc(1'b0, 10'd0, 1'b0, 2'd0, 5'd0,    1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd0, 5'h1D,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd1, 5'h1D,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // restart clears Z; same-cycle flag load uses old flags
    cyc(1'b1, 10'd0, 1'b1, 2'd0, 5'd3,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd0, 5'd3,    1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd0, 5'd3,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // halt address, branches suppressed in HALT, start recovers with flags cleared
    cyc(1'b0, 10'd63, 1'b1, 2'd3, 5'd5,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd5,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd63, 1'b1, 2'd0, 5'd1,   1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd0, 5'd1,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // cycle budget: start on the 8th RUN cycle keeps running, then a full budget times out
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(7);
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(8);
    idle(3);
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    // 3 taken, 2 not taken, then asynchronous reset mid-run
    for (int i = 0; i < 3; i++) cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 10'd0, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(1);
    s_rst = 1'b0; s_start = 1'b0; s_bv = 1'b1;
    issue();
    idle(1);
    cyc(1'b1, 10'd0, 1'b0, 2'd0, 5'd0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 10'd0, 1'b1, 2'd3, 5'd5,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(199) != 0);
      s_start = s_rst && ($urandom_range(7) == 0);
      s_pc    = ($urandom_range(24) == 0) ? 10'd63 : 10'($urandom_range(1023));
      s_bv    = ($urandom_range(3) != 0);
      s_kind  = 2'($urandom_range(3));
      s_imm   = 5'($urandom_range(31));
      s_fwe   = 1'($urandom_range(1));
      s_z     = 1'($urandom_range(1));
      s_n     = 1'($urandom_range(1));
      s_lwe   = ($urandom_range(3) == 0);
      s_la    = 4'($urandom_range(15));
      s_ld    = 4'($urandom_range(15));
      issue();
    end

    idle(1);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    if (q.size() > 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want at most 1", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch-resolution unit that produces the branch, taken, target and LOOKUP2 controls consumed by the program counter. It sits between the decoder/ALU and the PC. It holds the condition-flag register, evaluates branch conditions and holds a writable absolute-target lookup table. A run-control state machine declares program completion at a halt address or on a cycle-budget timeout.

## Interface
Parameters:
- HALT_PC, 10'd63, PC value that ends a run
- MAX_CYCLES, 4096, RUN-cycle budget before forced timeout halt (≥2)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; same pulse resets the PC
- pc  in  10  current PC value
- br_valid  in  1  decoded instruction is a branch
- br_kind  in  2  00 branch-if-Z, 01 branch-if-!Z, 10 branch-if-N, 11 unconditional absolute jump
- br_imm  in  5  kinds 00–10: signed relative offset; kind 11: LUT index (low 4 bits)
- flag_we  in  1  load ALU flags
- alu_z, alu_n  in  1 each  ALU zero / negative results
- lut_we  in  1  LUT write strobe
- lut_addr  in  4  LUT write address
- lut_data  in  4  LUT write data
- branch  out  1  branch instruction present (gated by RUN)
- taken  out  1  condition satisfied
- target  out  8  relative offset or absolute target
- LOOKUP2  out  1  1 = absolute target, 0 = relative
- busy  out  1  state is RUN
- done  out  1  state is HALT
- timeout  out  1  sticky: last halt caused by cycle budget

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: start → RUN.
- RUN: start → RUN (restart). Otherwise pc == HALT_PC → HALT. Otherwise cycle counter == MAX_CYCLES-1 → HALT with timeout set.
- HALT: start → RUN. All other inputs ignored.
- start has priority over every other event, including halt detection and timeout in the same cycle.
- On start:
  - Z, N flags cleared.
  - Cycle counter cleared.
  - timeout cleared.
  - LUT contents retained.
- Flags Z, N load alu_z/alu_n when flag_we=1 in RUN and start=0; otherwise they hold.
- Condition evaluation uses the registered flags. If flag_we and br_valid are both asserted in the same cycle, the pre-update flags decide the branch.
- branch = br_valid & (state==RUN).
- taken = branch & cond:
  - kind 00: cond = Z
  - kind 01: cond = !Z
  - kind 10: cond = N
  - kind 11: cond = 1
- Target for kinds 00–10: br_imm sign-extended to 8 bits (two's complement), LOOKUP2=0.
- Target for kind 11: {4'b0, lut[br_imm[3:0]]}, LOOKUP2=1.
- Outputs when branch=0: target=0, LOOKUP2=0.
- LUT: 16×4 registers.
  - Reset value of entry i is i.
  - Written when lut_we=1 in any state.
  - A write and a read of the same entry in the same cycle return the old value; the new value is visible the next cycle.
- Cycle counter: clog2(MAX_CYCLES) bits. Increments every RUN cycle and saturates; it does not wrap.

## Timing
- branch, taken, target and LOOKUP2 are combinational from inputs and registered state. The PC samples them at the next rising edge.
- busy, done and timeout are registered, driven directly from state.
- Reset values while RST_N=0, immediately and asynchronously:
  - state=IDLE
  - busy=0, done=0, timeout=0
  - Z=N=0, counter=0, lut[i]=i
  - branch=taken=LOOKUP2=0, target=0
- Halt latency: if pc==HALT_PC is sampled at edge k, done=1 after edge k, and branch is forced to 0 from that cycle onward.
- Reset asserted mid-run: immediate return to IDLE; LUT contents are restored to the reset pattern.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs taken_cnt[15:0] and not_taken_cnt[15:0].
  - Each counts RUN cycles with branch=1 and taken=1 or taken=0 respectively.
  - Both saturate at 16'hFFFF, clear on start and on reset, and hold in IDLE/HALT.
- BRANCH_STATS_EN undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Test plan
- Reset then start: IDLE → RUN.
  - Issue br_valid, kind 11, br_imm=5 → taken=1, LOOKUP2=1, target=8'h05.
  - Write lut[5]=4'hA, then repeat the jump → target=8'h0A.
- flag_we with alu_z=1, next cycle kind 00 with br_imm=5'h1D → taken=1, target=8'hFD, LOOKUP2=0. The same sequence with kind 01 → taken=0.
- Same cycle: flag_we (alu_z=1) and kind 00 with old Z=0 → taken=0. The following kind-00 branch → taken=1.
- Drive pc=63 in RUN → done=1, busy=0 next cycle. br_valid=1 afterwards → branch=0. start → busy=1, flags cleared.
- MAX_CYCLES=8, pc never 63 → done=1 and timeout=1 after exactly 8 RUN cycles. start in the same cycle as the 8th → stays RUN, timeout=0.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken branches → taken_cnt=3, not_taken_cnt=2. Assert RST_N low mid-run → all counters, flags and state reset asynchronously.
